// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS32 constants, fetch state encoding and next-PC select codes
package mips_pkg;

    // Primary opcode field values (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // sll $0,$0,0 - the canonical MIPS NOP
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_SEL_HOLD   = 2'd0,
        PC_SEL_SEQ    = 2'd1,
        PC_SEL_JUMP   = 2'd2,
        PC_SEL_BRANCH = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - combinational next-PC select with word-alignment of redirect targets
//
// Ports:
//   sel           in  next-PC source (hold / sequential / jump / branch)
//   pc            in  current PC
//   jump_target   in  jump destination (low two bits ignored)
//   branch_target in  branch destination (low two bits ignored)
//   pc_next       out selected next PC
//   pc_seq        out pc + 4, modulo 2^ADDR_W
module pc_next_mux
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  pc_sel_t           sel,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_next,
    output logic [ADDR_W-1:0] pc_seq
);

    logic [ADDR_W-1:0] jump_aligned;
    logic [ADDR_W-1:0] branch_aligned;

    // Natural overflow gives the required wrap from the top word to 0.
    assign pc_seq         = pc + ADDR_W'(4);
    assign jump_aligned   = {jump_target[ADDR_W-1:2], 2'b00};
    assign branch_aligned = {branch_target[ADDR_W-1:2], 2'b00};

    always_comb begin
        pc_next = pc;
        case (sel)
            PC_SEL_HOLD:   pc_next = pc;
            PC_SEL_SEQ:    pc_next = pc_seq;
            PC_SEL_JUMP:   pc_next = jump_aligned;
            PC_SEL_BRANCH: pc_next = branch_aligned;
            default:       pc_next = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MIPS32 instruction fetch stage with IF/ID register, stall skid buffer and redirect drain
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   imem_req/addr/ready/rdata instruction memory request/response handshake
//   stall                     hold IF/ID outputs, do not advance
//   jump, jump_target         jump redirect (priority over branch)
//   branch_taken, branch_target taken-branch redirect
//   instr, instr_pc, pc_plus4 IF/ID register contents
//   opcode                    instr[31:26] to the control unit
//   instr_valid               IF/ID holds a live instruction
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [5:0]        opcode,
    output logic              instr_valid
);

    fetch_state_t      state, state_next;
    pc_sel_t           pc_sel;
    logic [ADDR_W-1:0] pc, pc_next, pc_seq;

    // Skid buffer for a word that returned while stalled
    logic [31:0]       buf_instr;
    logic [ADDR_W-1:0] buf_pc;
    logic [ADDR_W-1:0] buf_pc_plus4;

    // Address of the request abandoned by a redirect; re-presented until it completes
    logic [ADDR_W-1:0] drain_addr;

    logic redirect;
    logic out_load_mem, out_load_buf, out_bubble, out_flush;
    logic buf_load, drain_load;

    assign redirect = jump | branch_taken;

    pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
        .sel           (pc_sel),
        .pc            (pc),
        .jump_target   (jump_target),
        .branch_target (branch_target),
        .pc_next       (pc_next),
        .pc_seq        (pc_seq)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        pc_sel       = PC_SEL_HOLD;
        out_load_mem = 1'b0;
        out_load_buf = 1'b0;
        out_bubble   = 1'b0;
        out_flush    = 1'b0;
        buf_load     = 1'b0;
        drain_load   = 1'b0;

        if (redirect) begin
            // Redirect wins over stall: the IF/ID word and any buffered word are wrong-path.
            pc_sel    = jump ? PC_SEL_JUMP : PC_SEL_BRANCH;
            out_flush = 1'b1;
            if ((state == S_FETCH || state == S_DRAIN) && !imem_ready) begin
                // A request is still outstanding; memory must see it complete at its
                // original address before the new target can be issued.
                state_next = S_DRAIN;
                drain_load = (state == S_FETCH);
            end else begin
                state_next = S_FETCH;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        pc_sel = PC_SEL_SEQ;
                        if (stall) begin
                            buf_load   = 1'b1;
                            state_next = S_HOLD;
                        end else begin
                            out_load_mem = 1'b1;
                        end
                    end else if (!stall) begin
                        out_bubble = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        out_load_buf = 1'b1;
                        state_next   = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // pc already holds the redirect target; the response is dropped.
                    if (imem_ready) begin
                        state_next = S_FETCH;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= ADDR_W'(RESET_PC);
            instr        <= NOP_WORD;
            instr_pc     <= '0;
            pc_plus4     <= '0;
            instr_valid  <= 1'b0;
            buf_instr    <= NOP_WORD;
            buf_pc       <= '0;
            buf_pc_plus4 <= '0;
            drain_addr   <= '0;
        end else begin
            pc <= pc_next;

            if (buf_load) begin
                buf_instr    <= imem_rdata;
                buf_pc       <= pc;
                buf_pc_plus4 <= pc_seq;
            end

            if (drain_load) begin
                drain_addr <= pc;
            end

            if (out_flush) begin
                instr       <= NOP_WORD;
                instr_valid <= 1'b0;
            end else if (out_load_mem) begin
                instr       <= imem_rdata;
                instr_pc    <= pc;
                pc_plus4    <= pc_seq;
                instr_valid <= 1'b1;
            end else if (out_load_buf) begin
                instr       <= buf_instr;
                instr_pc    <= buf_pc;
                pc_plus4    <= buf_pc_plus4;
                instr_valid <= 1'b1;
            end else if (out_bubble) begin
                instr_valid <= 1'b0;
            end
        end
    end

    assign imem_req  = (state == S_FETCH) || (state == S_DRAIN);
    assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;
    assign opcode    = instr[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic        instr_valid;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .pc_plus4      (pc_plus4),
        .opcode        (opcode),
        .instr_valid   (instr_valid)
    );

    always #5 clk = ~clk;

    // Instruction memory model: mem_lat wait states per request, mem_hold blocks completion.
    int   mem_lat = 0;
    logic mem_hold = 1'b0;
    int   wait_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h8C09_0004;
        return {6'b101011, a[25:0]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) wait_cnt <= 0;
        else if (!imem_req || imem_ready) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    assign imem_ready = imem_req && !mem_hold && (wait_cnt >= mem_lat);
    assign imem_rdata = mem_word(imem_addr);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: expected instruction stream, consumed when decode accepts (valid && !stall).
    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;
    exp_t exp_q[$];

    task automatic push_stream(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{pc: a, word: mem_word(a)});
            a = a + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] w;
        if (!rst && instr_valid && !stall && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            w = e.word;
            check("sb_instr", instr, w);
            check("sb_instr_pc", instr_pc, e.pc);
            check("sb_pc_plus4", pc_plus4, e.pc + 32'd4);
            check("sb_opcode", {26'd0, opcode}, {26'd0, w[31:26]});
        end
    end

    typedef struct {
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] instr;
        logic [31:0] ipc;
        logic [31:0] p4;
    } vec_t;
    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] old_addr;
        logic [31:0] prev_addr;
        logic        prev_wait;
        logic [31:0] vi;
        int          bubbles;

        // Reset release then zero-wait streaming, with a 3-cycle stall at instr_pc=8.
        vecs[0] = '{1'b0, 1'b0, 32'h00, 1'b0, 32'h0000_0000, 32'h00, 32'h00};
        vecs[1] = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h0000_0000, 32'h00, 32'h00};
        vecs[2] = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h2008_0005, 32'h00, 32'h04};
        vecs[3] = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h8C09_0004, 32'h04, 32'h08};
        vecs[4] = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'hAC00_0008, 32'h08, 32'h0C};
        vecs[5] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'hAC00_0008, 32'h08, 32'h0C};
        vecs[6] = '{1'b1, 1'b0, 32'h10, 1'b1, 32'hAC00_0008, 32'h08, 32'h0C};
        vecs[7] = '{1'b0, 1'b0, 32'h10, 1'b1, 32'hAC00_0008, 32'h08, 32'h0C};
        vecs[8] = '{1'b0, 1'b1, 32'h10, 1'b1, 32'hAC00_000C, 32'h0C, 32'h10};
        vecs[9] = '{1'b0, 1'b1, 32'h14, 1'b1, 32'hAC00_0010, 32'h10, 32'h14};

        #1;
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_stream(32'h0, 5);

        for (int i = 0; i < 10; i++) begin
            stall = vecs[i].stall;
            @(negedge clk);
            vi = vecs[i].instr;
            check($sformatf("v%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].req});
            if (vecs[i].req) check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].valid});
            check($sformatf("v%0d_instr", i), instr, vi);
            check($sformatf("v%0d_opcode", i), {26'd0, opcode}, {26'd0, vi[31:26]});
            check($sformatf("v%0d_instr_pc", i), instr_pc, vecs[i].ipc);
            check($sformatf("v%0d_pc_plus4", i), pc_plus4, vecs[i].p4);
            tick();
        end
        check("q_empty_stream", exp_q.size(), 32'd0);

        // Two-wait-state memory: bubbles between words, address stable while waiting.
        exp_q.delete();
        push_stream(32'h14, 4);
        mem_lat   = 2;
        prev_wait = 1'b0;
        prev_addr = '0;
        bubbles   = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (prev_wait) check("addr_stable", imem_addr, prev_addr);
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;
            if (!instr_valid) bubbles++;
            tick();
        end
        check("bubbles_seen", {31'd0, bubbles > 0}, 32'd1);
        check("q_empty_latency", exp_q.size(), 32'd0);

        // Jump while stalled flushes IF/ID and refetches from the target.
        mem_lat = 0;
        exp_q.delete();
        stall = 1'b1;
        tick();
        tick();
        jump        = 1'b1;
        jump_target = 32'h40;
        tick();
        jump = 1'b0;
        check("jmp_valid", {31'd0, instr_valid}, 32'd0);
        check("jmp_opcode", {26'd0, opcode}, 32'd0);
        check("jmp_instr", instr, 32'h0);
        check("jmp_req", {31'd0, imem_req}, 32'd1);
        check("jmp_addr", imem_addr, 32'h40);
        stall = 1'b0;
        push_stream(32'h40, 3);
        repeat (5) tick();
        check("q_empty_jump", exp_q.size(), 32'd0);

        // Jump + branch during a pending request: drain old address, jump target wins.
        exp_q.delete();
        mem_hold = 1'b1;
        tick();
        old_addr = imem_addr;
        check("pend_req", {31'd0, imem_req}, 32'd1);
        jump          = 1'b1;
        jump_target   = 32'h100;
        branch_taken  = 1'b1;
        branch_target = 32'h23;
        tick();
        jump         = 1'b0;
        branch_taken = 1'b0;
        check("drain_req", {31'd0, imem_req}, 32'd1);
        check("drain_addr", imem_addr, old_addr);
        check("drain_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check("drain_addr_hold", imem_addr, old_addr);
        mem_hold = 1'b0;
        tick();
        check("post_drain_addr", imem_addr, 32'h100);
        check("drain_discard", {31'd0, instr_valid}, 32'd0);
        push_stream(32'h100, 3);
        repeat (5) tick();
        check("q_empty_drain", exp_q.size(), 32'd0);

        // Second redirect during drain replaces the saved target.
        exp_q.delete();
        mem_hold      = 1'b1;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h23;
        tick();
        branch_taken = 1'b0;
        jump         = 1'b1;
        jump_target  = 32'h207;
        tick();
        jump     = 1'b0;
        mem_hold = 1'b0;
        tick();
        check("last_redirect_addr", imem_addr, 32'h204);

        // Unaligned branch target with zero-wait memory.
        branch_taken  = 1'b1;
        branch_target = 32'h23;
        tick();
        branch_taken = 1'b0;
        check("branch_align_addr", imem_addr, 32'h20);
        check("branch_valid", {31'd0, instr_valid}, 32'd0);

        // PC wrap from the top of the address space.
        jump        = 1'b1;
        jump_target = 32'hFFFF_FFF8;
        tick();
        jump = 1'b0;
        exp_q.delete();
        push_stream(32'hFFFF_FFF8, 4);
        repeat (7) tick();
        check("q_empty_wrap", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of a drain.
        exp_q.delete();
        mem_hold = 1'b1;
        tick();
        jump        = 1'b1;
        jump_target = 32'h80;
        tick();
        jump = 1'b0;
        check("pre_rst_drain_req", {31'd0, imem_req}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_instr_pc", instr_pc, 32'h0);
        check("mid_rst_pc_plus4", pc_plus4, 32'h0);
        tick();
        rst      = 1'b0;
        mem_hold = 1'b0;
        check("rel_idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("rel_req", {31'd0, imem_req}, 32'd1);
        check("rel_addr", imem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
